mux_universal_shift_reg: RTL and testbench
==========================================

# mux_universal_shift_reg

Parameterised universal shift register built from per-bit 4:1 mux-selected flop cells. It consumes the single-bit mux-based positive-edge storage element and extends it into a WIDTH-bit word store with hold, shift-right, shift-left and parallel-load modes. Optional rotation and a shift-frame counter pulse `frame_done` after WIDTH consecutive same-direction shifts. It is the next stage up from the mux-built flop and serves as a serial/parallel converter for downstream blocks.

## Interface
- `WIDTH`, default 4: register width in bits; legal range ≥ 2.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `mode`  input  2: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
- `rotate`  input  1: when 1, shifts recirculate the exiting bit instead of taking the serial input.
- `sin_r`  input  1: serial input entering at bit WIDTH-1 during SHR.
- `sin_l`  input  1: serial input entering at bit 0 during SHL.
- `d`  input  WIDTH: parallel load data.
- `q`  output  WIDTH: register contents.
- `sout_r`  output  1: q[0], the bit leaving on the next SHR.
- `sout_l`  output  1: q[WIDTH-1], the bit leaving on the next SHL.
- `shift_cnt`  output  $clog2(WIDTH): shifts completed in the current frame.
- `frame_done`  output  1: one-cycle pulse marking completion of a WIDTH-shift frame.

## Operation
- Reset: `q`=0, `shift_cnt`=0, `frame_done`=0, internal last-direction register = SHR. `rst` overrides `mode`.
- HOLD: `q` and `shift_cnt` keep their values. `frame_done`←0.
- LOAD: `q`←`d`, `shift_cnt`←0, `frame_done`←0. Direction register is unchanged.
- SHR: `q`←{rotate ? q[0] : sin_r, q[WIDTH-1:1]}.
- SHL: `q`←{q[WIDTH-2:0], rotate ? q[WIDTH-1] : sin_l}.
- Frame counting on SHR/SHL:
  - Direction differs from the last direction: `shift_cnt`←1, direction register updated, `frame_done`←0.
  - Same direction and `shift_cnt`==WIDTH-1: `shift_cnt`←0, `frame_done`←1.
  - Otherwise: `shift_cnt`+1, `frame_done`←0.
- The first shift after reset or LOAD counts as 1 regardless of direction.
- `rotate` affects data only, never counting.
- `sout_r` and `sout_l` are combinational taps of registered `q`, with no extra latency.

## Timing
- All outputs are registered except `sout_r` and `sout_l`, which are wires from `q`.
- Latency: a mode applied before edge N is reflected in `q` and `shift_cnt` after edge N.
- `frame_done` is high for exactly the cycle following the WIDTH-th same-direction shift edge, coincident with the completed `q`. It drops on the next edge whatever the mode.
- HOLD cycles inside a frame do not break the frame. A direction change or LOAD does.
- Reset mid-frame discards the partial count. A full WIDTH shifts is then needed for the next `frame_done`.
- Wrap-around: `shift_cnt` never reaches WIDTH. It goes WIDTH-1 → 0.

## Structure
- Shared package holds the mode encoding constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the typedef for the 2-bit mode.
- Sub-module `usr_bit_cell`: one 4:1 mux (hold/right-neighbour/left-neighbour/load) feeding one flop with synchronous reset. It is instantiated WIDTH times in a generate loop.
- End cells select `sin_r`/`sin_l` or the rotate tap through an extra 2:1 mux.
- The counter, direction register and `frame_done` flop live in the top module.

## Test plan
- Reset dominance: `rst`=1, mode=LOAD, `d`=4'hF → after the edge `q`=0000, `shift_cnt`=0, `frame_done`=0.
- Serial out, right: LOAD 1011, then 4×SHR with `sin_r`=0.
  - `q` = 0101, 0010, 0001, 0000.
  - `sout_r` before each edge = 1, 1, 0, 1.
  - `shift_cnt` = 1, 2, 3, 0.
  - `frame_done` high only after the 4th edge.
- Rotate left: LOAD 1000, `rotate`=1, 4×SHL → `q` = 0001, 0010, 0100, 1000, with `frame_done` pulse after the 4th edge.
- Direction change: LOAD 0000, SHR, SHR, SHL → `shift_cnt` = 1, 2, 1, and `frame_done` stays 0.
- HOLD inside a frame: 2×SHR, 3×HOLD, 2×SHR → `q` frozen during HOLD, `shift_cnt` = 2 through HOLD, `frame_done` after the 4th shift.
- Reset mid-frame: 3×SHR, then `rst` for 1 cycle → `shift_cnt`=0, `q`=0. The next 3 SHR give no `frame_done`; the 4th does.

Source files
------------

// File: rtl/mux_universal_shift_reg_pkg.sv
// mux_universal_shift_reg_pkg: mode encoding shared by the shift register and its bit cells
package mux_universal_shift_reg_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/mux_universal_shift_reg_cell.sv
// usr_bit_cell: one 4:1 mux (hold/upper neighbour/lower neighbour/load) feeding a sync-reset flop
module usr_bit_cell
  import mux_universal_shift_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  mode_t mode,
  input  logic  from_hi,
  input  logic  from_lo,
  input  logic  load,
  output logic  q
);
  logic nxt;
  always_comb nxt = mode == MODE_SHR  ? from_hi :
                    mode == MODE_SHL  ? from_lo :
                    mode == MODE_LOAD ? load    : q;
  always_ff @(posedge clk) q <= rst ? 1'b0 : nxt;
endmodule

// File: rtl/mux_universal_shift_reg.sv
// mux_universal_shift_reg: WIDTH-bit universal shift register with rotate and shift-frame counting
module mux_universal_shift_reg
  import mux_universal_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       rotate,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH)-1:0]   shift_cnt,
  output logic                       frame_done
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] from_hi, from_lo;
  logic [CW-1:0] cnt_n;
  logic shift, dir, dir_n, same, wrap;
  // end cells pick the serial input or the recirculated exiting bit
  assign from_hi = {rotate ? q[0] : sin_r, q[WIDTH-1:1]};
  assign from_lo = {q[WIDTH-2:0], rotate ? q[WIDTH-1] : sin_l};
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .from_hi (from_hi[i]),
      .from_lo (from_lo[i]),
      .load    (d[i]),
      .q       (q[i])
    );
  end
  // dir: 0 = SHR, 1 = SHL; a count of 0 makes the first shift land on 1 either way
  always_comb begin
    shift = mode == MODE_SHR || mode == MODE_SHL;
    dir_n = mode == MODE_SHL;
    same  = dir_n == dir;
    wrap  = same && shift_cnt == CW'(WIDTH - 1);
    cnt_n = mode == MODE_LOAD ? '0 :
            !shift            ? shift_cnt :
            !same             ? CW'(1) :
            wrap              ? '0 : shift_cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
      dir        <= 1'b0;
    end else begin
      shift_cnt  <= cnt_n;
      frame_done <= shift && wrap;
      dir        <= shift ? dir_n : dir;
    end
  end
endmodule

// File: tb/tb_mux_universal_shift_reg.sv
// tb_mux_universal_shift_reg: directed scenarios plus randomized run against a word-level model
module tb_mux_universal_shift_reg;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, rotate, sin_r, sin_l, sout_r, sout_l, frame_done;
  logic [1:0] mode, shift_cnt;
  logic [W-1:0] d, q;
  int checks = 0, errors = 0;
  logic [W-1:0] qm;
  int run;
  logic [1:0] ldir;
  logic dm;

  mux_universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .rotate(rotate), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // model: word arithmetic plus a run length of consecutive same-direction shifts
  task automatic drive(input logic [1:0] m, input logic rot, input logic sr, input logic sl,
                       input logic [W-1:0] dd, input logic r);
    logic inb;
    rst = r; mode = m; rotate = rot; sin_r = sr; sin_l = sl; d = dd;
    if (r) begin
      qm = '0; run = 0; ldir = 2'd1; dm = 1'b0;
    end else if (m == 2'd1 || m == 2'd2) begin
      inb = rot ? (m == 2'd1 ? qm[0] : qm[W-1]) : (m == 2'd1 ? sr : sl);
      qm  = m == 2'd1 ? (qm >> 1) | (W'(inb) << (W - 1)) : (qm << 1) | W'(inb);
      run = (m == ldir) ? run + 1 : 1;
      ldir = m;
      dm = (run % W) == 0;
    end else if (m == 2'd3) begin
      qm = dd; run = 0; dm = 1'b0;
    end else dm = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h exp 0", q); end
    checks++; if (shift_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", shift_cnt); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
  endtask

  task automatic test_serial_right();
    logic [3:0] eq[4];
    logic [1:0] ec[4];
    logic es[4];
    eq = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    ec = '{2'd1, 2'd2, 2'd3, 2'd0};
    es = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (sout_r !== es[k]) begin errors++; $display("FAIL shr_sout_r[%0d] got %b exp %b", k, sout_r, es[k]); end
      drive(2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      checks++; if (q !== eq[k]) begin errors++; $display("FAIL shr_q[%0d] got %b exp %b", k, q, eq[k]); end
      checks++; if (shift_cnt !== ec[k]) begin errors++; $display("FAIL shr_cnt[%0d] got %0d exp %0d", k, shift_cnt, ec[k]); end
      checks++; if (frame_done !== (k == 3)) begin errors++; $display("FAIL shr_done[%0d] got %b exp %b", k, frame_done, k == 3); end
    end
    drive(2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL shr_done_drop got %b exp 0", frame_done); end
  endtask

  task automatic test_rotate_left();
    logic [3:0] eq[4];
    eq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (sout_l !== qm[W-1]) begin errors++; $display("FAIL rol_sout_l[%0d] got %b exp %b", k, sout_l, qm[W-1]); end
      drive(2'd2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      checks++; if (q !== eq[k]) begin errors++; $display("FAIL rol_q[%0d] got %b exp %b", k, q, eq[k]); end
      checks++; if (frame_done !== (k == 3)) begin errors++; $display("FAIL rol_done[%0d] got %b exp %b", k, frame_done, k == 3); end
    end
  endtask

  task automatic test_direction_change();
    logic [1:0] ms[3];
    logic [1:0] ec[3];
    ms = '{2'd1, 2'd1, 2'd2};
    ec = '{2'd1, 2'd2, 2'd1};
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(ms[k], 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
      checks++; if (shift_cnt !== ec[k]) begin errors++; $display("FAIL dir_cnt[%0d] got %0d exp %0d", k, shift_cnt, ec[k]); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL dir_done[%0d] got %b exp 0", k, frame_done); end
    end
  endtask

  task automatic test_hold();
    logic [1:0] ms[7];
    ms = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(ms[k], 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      checks++; if (q !== qm) begin errors++; $display("FAIL hold_q[%0d] got %b exp %b", k, q, qm); end
      checks++; if (shift_cnt !== 2'(run % W)) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp %0d", k, shift_cnt, run % W); end
      checks++; if (frame_done !== (k == 6)) begin errors++; $display("FAIL hold_done[%0d] got %b exp %b", k, frame_done, k == 6); end
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) drive(2'd1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    drive(2'd1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    checks++; if (shift_cnt !== 2'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", shift_cnt); end
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL rstmid_q got %b exp 0", q); end
    for (int k = 0; k < 4; k++) begin
      drive(2'd1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      checks++; if (frame_done !== (k == 3)) begin errors++; $display("FAIL rstmid_done[%0d] got %b exp %b", k, frame_done, k == 3); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(2'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
            $urandom_range(31) == 0);
      checks++; if (q !== qm) begin errors++; $display("FAIL rnd_q[%0d] got %b exp %b", k, q, qm); end
      checks++; if (shift_cnt !== 2'(run % W)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", k, shift_cnt, run % W); end
      checks++; if (frame_done !== dm) begin errors++; $display("FAIL rnd_done[%0d] got %b exp %b", k, frame_done, dm); end
      checks++; if (sout_r !== qm[0]) begin errors++; $display("FAIL rnd_sout_r[%0d] got %b exp %b", k, sout_r, qm[0]); end
      checks++; if (sout_l !== qm[W-1]) begin errors++; $display("FAIL rnd_sout_l[%0d] got %b exp %b", k, sout_l, qm[W-1]); end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; rotate = 1'b0; sin_r = 1'b0; sin_l = 1'b0; d = '0;
    #2;
    test_reset();
    test_serial_right();
    test_rotate_left();
    test_direction_change();
    test_hold();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
